// File: rtl/cv32e40p_wb_scoreboard.sv
// Write-back stage and load scoreboard. Registers EX results onto write port A,
// matches LSU load returns to their destinations through an in-order tag FIFO
// and drives write port B, and flags RAW/WAW hazards against pending loads.
module cv32e40p_wb_scoreboard #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LSU_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_we_i,
   input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
   input  logic [DATA_WIDTH-1:0] ex_wdata_i,
   input  logic                  ld_issue_i,
   input  logic [ADDR_WIDTH-1:0] ld_waddr_i,
   output logic                  ld_ready_o,
   input  logic                  lsu_rvalid_i,
   input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_a_i,
   input  logic [ADDR_WIDTH-1:0] raddr_b_i,
   input  logic [ADDR_WIDTH-1:0] raddr_c_i,
   output logic [2:0]            raw_hazard_o,
   output logic                  waw_hazard_o,
   output logic [ADDR_WIDTH-1:0] waddr_a_o,
   output logic [DATA_WIDTH-1:0] wdata_a_o,
   output logic                  we_a_o,
   output logic [ADDR_WIDTH-1:0] waddr_b_o,
   output logic [DATA_WIDTH-1:0] wdata_b_o,
   output logic                  we_b_o,
   output logic                  spurious_rvalid_o
);

   // A depth-1 FIFO still needs a 1-bit pointer; it simply never moves.
   localparam int unsigned PtrW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(LSU_DEPTH) + 1;

   logic [ADDR_WIDTH-1:0] r_fifo_addr [LSU_DEPTH];
   logic [PtrW-1:0]       r_rd_ptr;
   logic [PtrW-1:0]       r_wr_ptr;
   logic [CntW-1:0]       r_count;

   logic                  r_we_a;
   logic [ADDR_WIDTH-1:0] r_waddr_a;
   logic [DATA_WIDTH-1:0] r_wdata_a;
   logic                  r_we_b;
   logic [ADDR_WIDTH-1:0] r_waddr_b;
   logic [DATA_WIDTH-1:0] r_wdata_b;
   logic                  r_spurious;

   logic                  w_not_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_push;
   logic [ADDR_WIDTH-1:0] w_head_addr;
   logic [PtrW-1:0]       w_rd_ptr_nxt;
   logic [PtrW-1:0]       w_wr_ptr_nxt;
   logic [LSU_DEPTH-1:0]  w_entry_vld;
   logic [2:0]            w_raw_hazard;
   logic                  w_ex_pending;

   assign w_not_full  = (r_count < CntW'(LSU_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_pop       = lsu_rvalid_i && !w_empty;
   // A push into a full FIFO is dropped unless the same cycle frees a slot.
   assign w_push      = ld_issue_i && (w_not_full || w_pop);
   assign w_head_addr = r_fifo_addr[r_rd_ptr];

   assign w_rd_ptr_nxt = (r_rd_ptr == PtrW'(LSU_DEPTH - 1)) ? '0 : r_rd_ptr + PtrW'(1);
   assign w_wr_ptr_nxt = (r_wr_ptr == PtrW'(LSU_DEPTH - 1)) ? '0 : r_wr_ptr + PtrW'(1);

   // Port A result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we_a    <= 1'b0;
         r_waddr_a <= '0;
         r_wdata_a <= '0;
      end else begin
         r_we_a <= ex_we_i && (ex_waddr_i != '0);
         if (ex_we_i) begin
            r_waddr_a <= ex_waddr_i;
            r_wdata_a <= ex_wdata_i;
         end
      end
   end

   // Tag FIFO storage, pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LSU_DEPTH; i++) begin
            r_fifo_addr[i] <= '0;
         end
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= ld_waddr_i;
            r_wr_ptr              <= w_wr_ptr_nxt;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_nxt;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CntW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CntW'(1);
         end
      end
   end

   // Port B load-return register and spurious-return flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we_b     <= 1'b0;
         r_waddr_b  <= '0;
         r_wdata_b  <= '0;
         r_spurious <= 1'b0;
      end else begin
         r_we_b     <= w_pop && (w_head_addr != '0);
         r_spurious <= lsu_rvalid_i && w_empty;
         if (w_pop) begin
            r_waddr_b <= w_head_addr;
            r_wdata_b <= lsu_rdata_i;
         end
      end
   end

   // An entry is valid when its distance from the read pointer is below the count.
   always_comb begin
      logic [PtrW-1:0] off;
      w_entry_vld = '0;
      for (int unsigned i = 0; i < LSU_DEPTH; i++) begin
         off            = PtrW'(i) - r_rd_ptr;
         w_entry_vld[i] = (CntW'(off) < r_count);
      end
   end

   // Hazard match of read/EX addresses against valid entries and the port B register.
   always_comb begin
      w_raw_hazard = '0;
      w_ex_pending = 1'b0;
      for (int unsigned i = 0; i < LSU_DEPTH; i++) begin
         if (w_entry_vld[i]) begin
            if (r_fifo_addr[i] == raddr_a_i)  w_raw_hazard[0] = 1'b1;
            if (r_fifo_addr[i] == raddr_b_i)  w_raw_hazard[1] = 1'b1;
            if (r_fifo_addr[i] == raddr_c_i)  w_raw_hazard[2] = 1'b1;
            if (r_fifo_addr[i] == ex_waddr_i) w_ex_pending    = 1'b1;
         end
      end
      if (r_we_b) begin
         if (r_waddr_b == raddr_a_i)  w_raw_hazard[0] = 1'b1;
         if (r_waddr_b == raddr_b_i)  w_raw_hazard[1] = 1'b1;
         if (r_waddr_b == raddr_c_i)  w_raw_hazard[2] = 1'b1;
         if (r_waddr_b == ex_waddr_i) w_ex_pending    = 1'b1;
      end
      // x0 loads sit in the FIFO but are never a hazard.
      if (raddr_a_i == '0)  w_raw_hazard[0] = 1'b0;
      if (raddr_b_i == '0)  w_raw_hazard[1] = 1'b0;
      if (raddr_c_i == '0)  w_raw_hazard[2] = 1'b0;
      if (ex_waddr_i == '0) w_ex_pending    = 1'b0;
   end

   assign ld_ready_o        = w_not_full;
   assign raw_hazard_o      = w_raw_hazard;
   assign waw_hazard_o      = ex_we_i && w_ex_pending;
   assign we_a_o            = r_we_a;
   assign waddr_a_o         = r_waddr_a;
   assign wdata_a_o         = r_wdata_a;
   assign we_b_o            = r_we_b;
   assign waddr_b_o         = r_waddr_b;
   assign wdata_b_o         = r_wdata_b;
   assign spurious_rvalid_o = r_spurious;

endmodule

// File: doc/cv32e40p_wb_scoreboard.md
# cv32e40p_wb_scoreboard

Write-back stage and load scoreboard that sits directly upstream of the integer/FP register file and drives both of its write ports. Port A carries registered EX-stage results. Port B carries load data returned by the LSU; the block matches each return to its destination register through an in-order tag FIFO. The block tracks destinations of outstanding loads and flags RAW/WAW hazards so the decoder can stall.

## Interface
Parameters:
- ADDR_WIDTH, 6: register address width; bit 5 selects the FP file, bits 4:0 the word.
- DATA_WIDTH, 32: data width.
- LSU_DEPTH, 2: maximum outstanding loads. Must be a power of 2, range 1..8.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ex_we_i  input  1  EX result valid this cycle.
- ex_waddr_i  input  ADDR_WIDTH  EX destination.
- ex_wdata_i  input  DATA_WIDTH  EX result.
- ld_issue_i  input  1  load accepted by LSU this cycle.
- ld_waddr_i  input  ADDR_WIDTH  load destination.
- ld_ready_o  output  1  a load may issue: tag FIFO not full.
- lsu_rvalid_i  input  1  load data return. No backpressure.
- lsu_rdata_i  input  DATA_WIDTH  load data.
- raddr_a_i, raddr_b_i, raddr_c_i  input  ADDR_WIDTH each  decoder read addresses.
- raw_hazard_o  output  3  bit k: read address k matches a pending load.
- waw_hazard_o  output  1  ex_waddr_i matches a pending load while ex_we_i=1.
- waddr_a_o / wdata_a_o / we_a_o  output  ADDR_WIDTH / DATA_WIDTH / 1  register file write port A.
- waddr_b_o / wdata_b_o / we_b_o  output  ADDR_WIDTH / DATA_WIDTH / 1  register file write port B.
- spurious_rvalid_o  output  1  one-cycle pulse: rvalid arrived with the tag FIFO empty.

## Operation
- **Port A register.** On each edge, we_a_o <= ex_we_i && (ex_waddr_i != 0). waddr_a_o and wdata_a_o capture their inputs only when ex_we_i=1.
- **Tag FIFO.** Depth LSU_DEPTH, circular, with rd/wr pointers and a count of width clog2(LSU_DEPTH)+1.
  - ld_issue_i pushes ld_waddr_i.
  - lsu_rvalid_i pops the head. The head address and lsu_rdata_i load into the port B register.
  - ld_ready_o = (count < LSU_DEPTH). It is computed from the registered count only; a same-cycle pop does not raise it.
  - Push while full is an upstream protocol violation. The FIFO ignores it and state is unchanged.
  - Push and pop in the same cycle: both occur and count is unchanged. This is legal when full.
  - Pointers wrap modulo LSU_DEPTH.
- **Port B register.** we_b_o <= lsu_rvalid_i && (count != 0) && (head addr != 0).
  - A load to x0 is popped and its data discarded; no write occurs.
  - rvalid with count=0: no pop, we_b_o <= 0, and spurious_rvalid_o pulses the next cycle.
- **Pending set.** All valid tag FIFO entries, plus the port B register while we_b_o=1. Address 0 is never pending.
- **Hazard outputs.** Combinational from current state and inputs:
  - raw_hazard_o[k] = raddr_k is in the pending set.
  - waw_hazard_o = ex_we_i && ex_waddr_i in the pending set.
  - Match compares all ADDR_WIDTH bits, so FP and integer registers never alias.
- **Write ordering.** Port A and port B never target the same address in the same cycle, given that upstream honours waw_hazard_o. If they do, the register file's port-B priority applies; the block does not arbitrate.

## Timing
- Reset: we_a_o=0, we_b_o=0, waddr_*_o=0, wdata_*_o=0, FIFO empty, ld_ready_o=1, raw_hazard_o=0 (given inputs), waw_hazard_o=0, spurious_rvalid_o=0.
- Reset mid-operation clears all pending entries immediately. Later rvalids are treated as spurious.
- EX latency: ex_we_i in cycle N gives we_a_o in N+1; the register file holds the value from N+2.
- Load latency: rvalid in N gives we_b_o in N+1. The address stays pending through N+1 and is clear in N+2.
- Issue in N: the address is pending from N+1.
- Issue and return in the same cycle to the same address: the new entry remains pending after the old one retires.
- Two outstanding loads to the same address: still pending after the first return, until the second retires.

## Test plan
- **EX write.** ex_we_i=1, waddr=0x05, wdata=0xDEADBEEF in cycle 0 -> cycle 1: we_a_o=1, waddr_a_o=0x05, wdata_a_o=0xDEADBEEF. waddr=0x00 -> we_a_o stays 0.
- **Single load.** Issue to 0x23 in cycle 0. raddr_a_i=0x23 -> raw_hazard_o[0]=1 in cycles 1–3. rvalid with data 0x12345678 in cycle 2 -> cycle 3: we_b_o=1, waddr_b_o=0x23. Cycle 4: raw_hazard_o=0. raddr=0x03 never flags.
- **Full FIFO, LSU_DEPTH=2.** Issue to 0x01, then 0x02 -> ld_ready_o=0. Issue plus rvalid in the same cycle -> count stays 2. Returns retire in order 0x01, 0x02.
- **WAW.** Load pending to 0x07; ex_we_i=1, ex_waddr_i=0x07 -> waw_hazard_o=1. ex_waddr_i=0x08 -> waw_hazard_o=0.
- **Spurious and reset.** rvalid with the FIFO empty -> spurious_rvalid_o=1 for exactly one cycle, we_b_o=0. Assert rst_n=0 with 2 loads pending -> hazards clear and ld_ready_o=1 immediately.
- **Load to x0.** Issue to 0x00, then return -> no we_b_o, and no hazard on raddr 0x00.
